// File: rtl/des_pkg.sv
// Shared types and constants for the DES result collector.
// FSM state encoding, restart command word and FIFO entry layout.
package des_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        ADVANCE = 3'd2,
        GUARD   = 3'd3,
        RESTART = 3'd4,
        HOLD    = 3'd5
    } state_t;

    localparam logic [31:0] CMD_RESTART = 32'h3;
    localparam int ENTRY_W = 129;

    typedef struct packed {
        logic        is_final;
        logic [63:0] counter;
        logic [63:0] ciphertext;
    } entry_t;

endpackage

// File: rtl/des_result_fifo.sv
// Result FIFO with zero-latency head view and modulo-DEPTH pointers.
// Pushes while full and pops while empty are ignored.
module des_result_fifo #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 129
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       head_data,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_C = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign valid     = (count != '0);
    assign full      = (count == DEPTH_C);
    assign do_push   = push & ~full;
    assign do_pop    = pop & valid;
    assign head_data = valid ? mem[rd_ptr] : '0;

    // Storage write; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/des_result_collector.sv
// Collects DES wrapper results into a FIFO and sequences advance/restart.
// Optional DES_COLLECT_AUTO_RESTART_EN issues a restart after a final result.
module des_result_collector
    import des_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   des_done,
    input  logic                   des_test_res_ready,
    input  logic [63:0]            des_counter,
    input  logic [63:0]            des_ciphertext,
    output logic                   advance_test_cmd,
    output logic                   cmd_valid,
    output logic [31:0]            cmd,
    input  logic                   cmd_read,
    input  logic                   rd_en,
    output logic                   rd_valid,
    output logic                   rd_final,
    output logic [63:0]            rd_counter,
    output logic [63:0]            rd_ciphertext,
    output logic [$clog2(DEPTH):0] fifo_count
);

    state_t            state;
    logic              final_r;
    logic              push;
    logic              full;
    entry_t            push_entry;
    entry_t            head_entry;
    logic [ENTRY_W-1:0] head_data;

    assign push       = (state == CAPTURE);
    assign push_entry = '{is_final:   final_r,
                          counter:    des_counter,
                          ciphertext: des_ciphertext};
    assign head_entry    = entry_t'(head_data);
    assign rd_final      = head_entry.is_final;
    assign rd_counter    = head_entry.counter;
    assign rd_ciphertext = head_entry.ciphertext;

    des_result_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (rd_en),
        .head_data (head_data),
        .valid     (rd_valid),
        .full      (full),
        .count     (fifo_count)
    );

    // Control FSM with registered advance/command outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            final_r          <= 1'b0;
            advance_test_cmd <= 1'b0;
            cmd_valid        <= 1'b0;
            cmd              <= '0;
        end else begin
            advance_test_cmd <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!full && des_done) begin
                        final_r <= 1'b1;
                        state   <= CAPTURE;
                    end else if (!full && des_test_res_ready) begin
                        final_r <= 1'b0;
                        state   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (final_r) begin
`ifdef DES_COLLECT_AUTO_RESTART_EN
                        state     <= RESTART;
                        cmd_valid <= 1'b1;
                        cmd       <= CMD_RESTART;
`else
                        state     <= HOLD;
`endif
                    end else begin
                        state            <= ADVANCE;
                        advance_test_cmd <= 1'b1;
                    end
                end
                ADVANCE: state <= GUARD;
                GUARD:   state <= IDLE;
                RESTART: begin
                    if (cmd_read) begin
                        state     <= IDLE;
                        cmd_valid <= 1'b0;
                        cmd       <= '0;
                    end
                end
                HOLD: begin
                    if (!des_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_result_collector.sv
// Self-checking bench for des_result_collector against a queue model.
// Covers test mode, final results (HOLD or RESTART), backpressure, reset.
module tb_des_result_collector;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        des_done;
    logic        des_test_res_ready;
    logic [63:0] des_counter;
    logic [63:0] des_ciphertext;
    logic        advance_test_cmd;
    logic        cmd_valid;
    logic [31:0] cmd;
    logic        cmd_read;
    logic        rd_en;
    logic        rd_valid;
    logic        rd_final;
    logic [63:0] rd_counter;
    logic [63:0] rd_ciphertext;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    logic [128:0] exp_q[$];

    des_result_collector #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .des_done           (des_done),
        .des_test_res_ready (des_test_res_ready),
        .des_counter        (des_counter),
        .des_ciphertext     (des_ciphertext),
        .advance_test_cmd   (advance_test_cmd),
        .cmd_valid          (cmd_valid),
        .cmd                (cmd),
        .cmd_read           (cmd_read),
        .rd_en              (rd_en),
        .rd_valid           (rd_valid),
        .rd_final           (rd_final),
        .rd_counter         (rd_counter),
        .rd_ciphertext      (rd_ciphertext),
        .fifo_count         (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [128:0] obs,
                       input logic [128:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic check_head(input string tag);
        chk({tag, "_count"}, 129'(fifo_count), 129'(exp_q.size()));
        chk({tag, "_valid"}, 129'(rd_valid), 129'(exp_q.size() != 0));
        if (exp_q.size() != 0)
            chk({tag, "_head"}, {rd_final, rd_counter, rd_ciphertext}, exp_q[0]);
        else
            chk({tag, "_head0"}, {rd_final, rd_counter, rd_ciphertext}, '0);
    endtask

    // Wrapper-side test result: hold ready until advance is seen.
    task automatic send_test(input logic [63:0] c, input logic [63:0] t,
                             input int exp_lat);
        int lat;
        bit seen;
        lat = 0;
        seen = 1'b0;
        des_test_res_ready = 1'b1;
        des_counter = c;
        des_ciphertext = t;
        for (int i = 1; i <= 20 && !seen; i++) begin
            step();
            if (advance_test_cmd) begin
                seen = 1'b1;
                lat = i;
            end
        end
        chk("adv_seen", 129'(seen), 129'(1));
        chk("adv_lat", 129'(lat), 129'(exp_lat));
        des_test_res_ready = 1'b0;
        if (seen) exp_q.push_back({1'b0, c, t});
        check_head("push");
        step();
        chk("adv_pulse", 129'(advance_test_cmd), 129'(0));
        step();
    endtask

    task automatic pop_one(input string tag);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        check_head(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        logic [63:0] c;
        logic [63:0] t;
        int k;
        int restarts;
        rst = 1'b1;
        des_done = 1'b0;
        des_test_res_ready = 1'b0;
        des_counter = '0;
        des_ciphertext = '0;
        cmd_read = 1'b0;
        rd_en = 1'b0;
        step();
        step();
        rst = 1'b0;

        chk("rst_adv", 129'(advance_test_cmd), 129'(0));
        chk("rst_cmd_valid", 129'(cmd_valid), 129'(0));
        chk("rst_cmd", 129'(cmd), 129'(0));
        check_head("rst");

        send_test(64'h10, 64'hA5A5, 2);
        chk("t1_final", 129'(rd_final), 129'(0));
        pop_one("t1_pop");

        for (int i = 0; i < 4; i++) begin
            send_test(rnd64(), rnd64(), 2);
            if ($urandom_range(0, 1) == 1) pop_one("rnd_pop");
        end
        while (exp_q.size() != 0) pop_one("rnd_drain");

        // Backpressure: fifth result waits for space.
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_test(rnd64(), rnd64(), 2);
        chk("full_count", 129'(fifo_count), 129'(DEPTH));
        c = rnd64();
        t = rnd64();
        des_test_res_ready = 1'b1;
        des_counter = c;
        des_ciphertext = t;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("full_no_adv", 129'(advance_test_cmd), 129'(0));
            check_head("full_hold");
        end
        pop_one("full_pop");
        send_test(c, t, 2);
        chk("full_refill", 129'(fifo_count), 129'(DEPTH));
        for (int i = 0; i < DEPTH; i++) pop_one("full_drain");

        // Simultaneous push and pop at count 2.
        do_reset();
        send_test(rnd64(), rnd64(), 2);
        send_test(rnd64(), rnd64(), 2);
        c = rnd64();
        t = rnd64();
        des_test_res_ready = 1'b1;
        des_counter = c;
        des_ciphertext = t;
        step();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        des_test_res_ready = 1'b0;
        chk("simul_adv", 129'(advance_test_cmd), 129'(1));
        void'(exp_q.pop_front());
        exp_q.push_back({1'b0, c, t});
        chk("simul_count", 129'(fifo_count), 129'(2));
        check_head("simul");
        step();
        step();
        pop_one("simul_pop1");
        pop_one("simul_pop2");
        pop_one("empty_pop");

`ifdef DES_COLLECT_AUTO_RESTART_EN
        // Final result with automatic restart.
        do_reset();
        restarts = 0;
        c = 64'h1234;
        t = rnd64();
        des_done = 1'b1;
        des_counter = c;
        des_ciphertext = t;
        step();
        chk("rs_no_cmd_early", 129'(cmd_valid), 129'(0));
        step();
        exp_q.push_back({1'b1, c, t});
        check_head("rs_push");
        k = $urandom_range(1, 4);
        for (int i = 0; i < k; i++) begin
            chk("rs_cmd_valid", 129'(cmd_valid), 129'(1));
            chk("rs_cmd", 129'(cmd), 129'(32'h3));
            step();
        end
        chk("rs_cmd_valid_last", 129'(cmd_valid), 129'(1));
        cmd_read = 1'b1;
        des_done = 1'b0;
        if (cmd_valid) restarts++;
        step();
        cmd_read = 1'b0;
        chk("rs_cmd_drop", 129'(cmd_valid), 129'(0));
        chk("rs_cmd_zero", 129'(cmd), 129'(0));
        for (int i = 0; i < 3; i++) begin
            if (cmd_valid) restarts++;
            step();
        end
        chk("rs_once", 129'(restarts), 129'(1));
        check_head("rs_after");

        // Reset while a restart is pending.
        do_reset();
        send_test(rnd64(), rnd64(), 2);
        send_test(rnd64(), rnd64(), 2);
        des_done = 1'b1;
        step();
        step();
        chk("rr_cmd_valid", 129'(cmd_valid), 129'(1));
        chk("rr_count3", 129'(fifo_count), 129'(3));
`else
        // Final result without auto-restart: hold until done falls.
        do_reset();
        restarts = 0;
        c = rnd64();
        t = rnd64();
        des_done = 1'b1;
        des_counter = c;
        des_ciphertext = t;
        step();
        chk("hd_cmd0", 129'(cmd_valid), 129'(0));
        step();
        exp_q.push_back({1'b1, c, t});
        check_head("hd_push");
        step();
        c = rnd64();
        t = rnd64();
        des_test_res_ready = 1'b1;
        des_counter = c;
        des_ciphertext = t;
        for (int i = 0; i < 2; i++) begin
            step();
            if (cmd_valid) restarts++;
            chk("hd_no_adv", 129'(advance_test_cmd), 129'(0));
            check_head("hd_hold");
        end
        des_done = 1'b0;
        send_test(c, t, 3);
        chk("hd_no_cmd", 129'(restarts + int'(cmd_valid)), 129'(0));
        pop_one("hd_pop1");
        pop_one("hd_pop2");

        // Reset while holding a final result.
        do_reset();
        send_test(rnd64(), rnd64(), 2);
        send_test(rnd64(), rnd64(), 2);
        des_done = 1'b1;
        step();
        step();
        chk("rr_count3", 129'(fifo_count), 129'(3));
        k = 0;
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        des_done = 1'b0;
        exp_q.delete();
        chk("rr_cmd_valid0", 129'(cmd_valid), 129'(0));
        chk("rr_cmd0", 129'(cmd), 129'(0));
        chk("rr_adv0", 129'(advance_test_cmd), 129'(0));
        check_head("rr");
        step();
        check_head("rr_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
